// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - state encoding and step-count helpers shared by seq_mult_hs
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Multiplier bits consumed per CALC cycle
  function automatic int bits_per_step(input bit radix4);
    return radix4 ? 2 : 1;
  endfunction

  // Number of CALC cycles needed to consume the whole multiplier
  function automatic int steps_for(input int width, input bit radix4);
    return width / bits_per_step(radix4);
  endfunction

  // Step counter width able to hold 0..steps
  function automatic int cnt_width(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/seq_mult_step.sv
// rtl/seq_mult_step.sv - one combinational accumulate-and-shift step (MSB-first multiplier scan)
module seq_mult_step #(
  parameter int WIDTH = 8,
  parameter int BITS  = 1
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [BITS-1:0]    mbits,
  input  logic [WIDTH-1:0]   mag,
  input  logic [WIDTH+1:0]   mag3,
  output logic [2*WIDTH-1:0] next_acc
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] pp;

  generate
    if (BITS == 2) begin : g_radix4
      // Partial product is 0, 1x, 2x or the precomputed 3x of the magnitude
      always_comb begin
        pp = '0;
        case (mbits)
          2'd0:    pp = '0;
          2'd1:    pp = PW'(mag);
          2'd2:    pp = PW'({mag, 1'b0});
          default: pp = PW'(mag3);
        endcase
      end
    end else begin : g_radix2
      logic unused_mag3;
      assign unused_mag3 = ^mag3;
      // Partial product is either the magnitude or zero
      always_comb begin
        pp = mbits[0] ? PW'(mag) : '0;
      end
    end
  endgenerate

  // Scale the running sum by the radix and add this step's partial product
  assign next_acc = (acc << BITS) + pp;

endmodule

// File: rtl/seq_mult_hs.sv
// rtl/seq_mult_hs.sv - handshaked sequential signed/unsigned multiplier; RADIX4_EN selects two bits per cycle
module seq_mult_hs
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

`ifdef RADIX4_EN
  localparam bit RADIX4 = 1'b1;
`else
  localparam bit RADIX4 = 1'b0;
`endif
  localparam int BITS  = bits_per_step(RADIX4);
  localparam int STEPS = steps_for(WIDTH, RADIX4);
  localparam int CW    = cnt_width(STEPS);
  localparam int PW    = 2 * WIDTH;

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("seq_mult_hs: WIDTH must be at least 2");
    end
    if (RADIX4 && (WIDTH % 2 != 0)) begin : g_bad_radix4
      $error("seq_mult_hs: RADIX4_EN requires an even WIDTH");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH+1:0] mag3;
  logic             neg;
  logic [PW-1:0]    acc, acc_nxt, p_reg;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;
  logic             accept, last_step;

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) as an unsigned value
  always_comb begin
    in_mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
    in_mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
  end

  assign accept    = in_ready && in_valid;
  assign last_step = (cnt == CW'(STEPS - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ST_CALC;
      end
      ST_CALC: begin
        if (last_step) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef RADIX4_EN
  // Triple of the multiplicand, formed once per operation so each step is a plain select
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      mag3 <= '0;
    else if (accept) mag3 <= {2'b00, in_mag_a} + {1'b0, in_mag_a, 1'b0};
  end
`else
  assign mag3 = {2'b00, mag_a};
`endif

  seq_mult_step #(
    .WIDTH (WIDTH),
    .BITS  (BITS)
  ) u_step (
    .acc      (acc),
    .mbits    (mplr[WIDTH-1 -: BITS]),
    .mag      (mag_a),
    .mag3     (mag3),
    .next_acc (acc_nxt)
  );

  // Operand latches, step counter, accumulator and signed result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      mag_a <= '0;
      mplr  <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      p_reg <= '0;
    end else if (accept) begin
      cnt   <= '0;
      mag_a <= in_mag_a;
      mplr  <= in_mag_b;
      neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc   <= '0;
    end else if (state == ST_CALC) begin
      cnt  <= cnt + CW'(1);
      mplr <= mplr << BITS;
      acc  <= acc_nxt;
      if (last_step) p_reg <= neg ? -acc_nxt : acc_nxt;
    end
  end

  assign p = p_reg;

endmodule

// File: tb/tb_seq_mult_hs.sv
// tb/tb_seq_mult_hs.sv - self-checking bench for seq_mult_hs (honours RADIX4_EN)
module tb_seq_mult_hs;

`ifdef RADIX4_EN
  localparam int STEPS = 4;
`else
  localparam int STEPS = 8;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  int checks = 0;
  int errors = 0;

  seq_mult_hs #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic        vs;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic s);
    int xi;
    int yi;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    return 16'(xi * yi);
  endfunction

  // One full transaction; hs_ok gathers handshake/stability observations along the way
  task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xs,
                        input int stall, input bit noisy,
                        output logic [15:0] got, output int lat, output bit hs_ok);
    int n;
    hs_ok = 1'b1;
    @(negedge clk);
    a = xa; b = xb; is_signed = xs; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) hs_ok = 1'b0;
    @(negedge clk);
    in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready || !busy) hs_ok = 1'b0;
      if (noisy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    got = p;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || p !== got) hs_ok = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    if (out_valid || !in_ready || busy || p !== got) hs_ok = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[13];
    logic [15:0] got;
    int          lat;
    bit          hs;
    bit          seen;
    logic [7:0]  ra, rb;
    logic        rs;

    reset = 1'b0; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_p", 32'(p), 32'd0);
    reset = 1'b1;

    vecs[0]  = '{8'd10,  8'd2,   1'b1, 16'd20};
    vecs[1]  = '{8'hF6,  8'd2,   1'b1, 16'hFFEC};
    vecs[2]  = '{8'd10,  8'hFE,  1'b1, 16'hFFEC};
    vecs[3]  = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
    vecs[4]  = '{8'h80,  8'h80,  1'b1, 16'h4000};
    vecs[5]  = '{8'h80,  8'h7F,  1'b1, 16'hC080};
    vecs[6]  = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
    vecs[7]  = '{8'h80,  8'd2,   1'b0, 16'h0100};
    vecs[8]  = '{8'd10,  8'd0,   1'b1, 16'h0000};
    vecs[9]  = '{8'd0,   8'd2,   1'b1, 16'h0000};
    vecs[10] = '{8'h7F,  8'h7F,  1'b1, 16'h3F01};
    vecs[11] = '{8'hFF,  8'd1,   1'b1, 16'hFFFF};
    vecs[12] = '{8'hFF,  8'h80,  1'b0, 16'h7F80};

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vs, 0, 1'b0, got, lat, hs);
      check($sformatf("vec%0d_p", i), 32'(got), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(STEPS));
      check($sformatf("vec%0d_handshake", i), 32'(hs), 32'd1);
    end

    // Back-pressure: five stalled cycles in DONE, result held
    run_op(8'd13, 8'd11, 1'b0, 5, 1'b0, got, lat, hs);
    check("stall_p", 32'(got), 32'd143);
    check("stall_hold", 32'(hs), 32'd1);

    // Reset during CALC aborts the operation
    @(negedge clk);
    a = 8'd5; b = 8'd9; is_signed = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_p", 32'(p), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < STEPS + 3; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    run_op(8'd7, 8'd6, 1'b1, 0, 1'b0, got, lat, hs);
    check("after_abort_p", 32'(got), 32'd42);
    check("after_abort_latency", 32'(lat), 32'(STEPS));

    // Randomised operations with noisy inputs and consumer stalls
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, $urandom_range(0, 3), 1'b1, got, lat, hs);
      check($sformatf("rand%0d_p a=%0h b=%0h s=%0d", i, ra, rb, rs), 32'(got), 32'(ref_mul(ra, rb, rs)));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(STEPS));
      check($sformatf("rand%0d_handshake", i), 32'(hs), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
